// File: rtl/blk_round_ctrl.sv
// blk_round_ctrl: iterative 128-bit cipher round controller sharing one Subsell_layer; optional abort via BLK_ABORT_EN.
// Latency ROUNDS+2 cycles from accepted start to done; each cycle with rk_valid_i low in FETCH adds one.
// Key fetch waits indefinitely on rk_valid_i; start_i is ignored while busy.

module Subsell_layer (
   input  logic [127:0] x_i,
   output logic [127:0] y_o
);
   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] r;
      case (n)
         4'h0: r = 4'h0;
         4'h1: r = 4'h3;
         4'h2: r = 4'h7;
         4'h3: r = 4'hE;
         4'h4: r = 4'hD;
         4'h5: r = 4'h4;
         4'h6: r = 4'hA;
         4'h7: r = 4'h9;
         4'h8: r = 4'hC;
         4'h9: r = 4'hF;
         4'hA: r = 4'h1;
         4'hB: r = 4'h8;
         4'hC: r = 4'hB;
         4'hD: r = 4'h2;
         4'hE: r = 4'h6;
         default: r = 4'h5;
      endcase
      return r;
   endfunction

   always_comb begin
      y_o = '0;
      for (int i = 0; i < 32; i++) y_o[4*i +: 4] = sbox(x_i[4*i +: 4]);
   end
endmodule

module blk_round_ctrl #(
   parameter int ROUNDS = 25,
   parameter int CNT_W  = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [127:0]     din_i,
   output logic             rk_req_o,
   output logic [CNT_W-1:0] rk_idx_o,
   input  logic             rk_valid_i,
   input  logic [127:0]     rk_i,
`ifdef BLK_ABORT_EN
   input  logic             abort_i,
`endif
   output logic             busy_o,
   output logic             done_o,
   output logic [127:0]     dout_o
);
   typedef enum logic [1:0] {IDLE, FETCH, DONE} fsm_e;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS);

   fsm_e             fsm_q;
   logic [127:0]     state_q;
   logic [127:0]     dout_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rk_req_q;
   logic             busy_q;
   logic             done_q;
   logic [127:0]     key_mix;
   logic [127:0]     sub_out;
   logic [127:0]     state_d;
   logic             abort_w;

`ifdef BLK_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   assign key_mix = state_q ^ rk_i;

   Subsell_layer u_sub (
      .x_i (key_mix),
      .y_o (sub_out)
   );

   // ShiftRow: rows rotated left by 0, 1, 12 and 13 bits
   assign state_d = {sub_out[127:96],
                     sub_out[94:64], sub_out[95],
                     sub_out[51:32], sub_out[63:52],
                     sub_out[18:0],  sub_out[31:19]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q    <= IDLE;
         state_q  <= '0;
         dout_q   <= '0;
         cnt_q    <= '0;
         rk_req_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (start_i) begin
                  state_q  <= din_i;
                  cnt_q    <= '0;
                  rk_req_q <= 1'b1;
                  busy_q   <= 1'b1;
                  fsm_q    <= FETCH;
               end
            end
            FETCH: begin
               // abort beats a same-cycle handshake; the key is dropped
               if (abort_w) begin
                  rk_req_q <= 1'b0;
                  busy_q   <= 1'b0;
                  fsm_q    <= IDLE;
               end else if (rk_valid_i) begin
                  if (cnt_q == LAST) begin
                     dout_q   <= key_mix;
                     rk_req_q <= 1'b0;
                     done_q   <= 1'b1;
                     fsm_q    <= DONE;
                  end else begin
                     state_q <= state_d;
                     cnt_q   <= cnt_q + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               fsm_q  <= IDLE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign rk_req_o = rk_req_q;
   assign rk_idx_o = cnt_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign dout_o   = dout_q;
endmodule

// File: tb/tb_blk_round_ctrl.sv
// Bench for blk_round_ctrl: a ROUNDS=1 instance driven with directed vectors, and a ROUNDS=25
// instance tracked every cycle against a transaction-level reference cipher.
module tb_blk_round_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   logic         rst;
   logic         a_start, a_rk_valid, a_req, a_busy, a_done;
   logic [127:0] a_din, a_rk, a_dout;
   logic [4:0]   a_idx;
   logic         b_start, b_rk_valid, b_req, b_busy, b_done;
   logic [127:0] b_din, b_rk, b_dout;
   logic [4:0]   b_idx;
   logic [127:0] a_keys [0:25];
   logic [127:0] b_keys [0:25];
   logic         b_ab;

`ifdef BLK_ABORT_EN
   logic a_abort, b_abort;
   assign b_ab = b_abort;
`else
   assign b_ab = 1'b0;
`endif

   assign a_rk = a_keys[a_idx];
   assign b_rk = b_keys[b_idx];

   blk_round_ctrl #(.ROUNDS(1), .CNT_W(5)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(a_start), .din_i(a_din),
      .rk_req_o(a_req), .rk_idx_o(a_idx), .rk_valid_i(a_rk_valid), .rk_i(a_rk),
`ifdef BLK_ABORT_EN
      .abort_i(a_abort),
`endif
      .busy_o(a_busy), .done_o(a_done), .dout_o(a_dout)
   );

   blk_round_ctrl #(.ROUNDS(25), .CNT_W(5)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(b_start), .din_i(b_din),
      .rk_req_o(b_req), .rk_idx_o(b_idx), .rk_valid_i(b_rk_valid), .rk_i(b_rk),
`ifdef BLK_ABORT_EN
      .abort_i(b_abort),
`endif
      .busy_o(b_busy), .done_o(b_done), .dout_o(b_dout)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference cipher
   function automatic logic [127:0] sub_cells(input logic [127:0] x);
      logic [3:0]   sb [0:15];
      logic [127:0] y;
      sb = '{4'h0, 4'h3, 4'h7, 4'hE, 4'hD, 4'h4, 4'hA, 4'h9,
             4'hC, 4'hF, 4'h1, 4'h8, 4'hB, 4'h2, 4'h6, 4'h5};
      y = '0;
      for (int i = 0; i < 32; i++) y[4*i +: 4] = sb[x[4*i +: 4]];
      return y;
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
      logic [63:0] ww;
      ww = {w, w} << n;
      return ww[63:32];
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] x);
      return {rotl(x[127:96], 0), rotl(x[95:64], 1), rotl(x[63:32], 12), rotl(x[31:0], 13)};
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] din, input int rounds,
                                              input logic [127:0] k [0:25]);
      logic [127:0] s;
      s = din;
      for (int r = 0; r < rounds; r++) s = shift_rows(sub_cells(s ^ k[r]));
      return s ^ k[rounds];
   endfunction

   // Transaction tracker for the ROUNDS=25 instance
   bit           m_busy = 0, m_req = 0, m_done = 0;
   int           m_idx = 0;
   logic [127:0] m_din = '0, m_dout = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_req = 0; m_done = 0; m_idx = 0; m_dout = '0;
      end else if (m_done) begin
         m_done = 0; m_busy = 0;
      end else if (m_req && b_ab) begin
         m_req = 0; m_busy = 0;
      end else if (m_req && b_rk_valid) begin
         if (m_idx == 25) begin
            m_req = 0; m_done = 1;
            m_dout = model_enc(m_din, 25, b_keys);
         end else begin
            m_idx++;
         end
      end else if (!m_busy && b_start) begin
         m_din = b_din; m_idx = 0; m_req = 1; m_busy = 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("b_busy", b_busy, m_busy);
         chk("b_done", b_done, m_done);
         chk("b_req", b_req, m_req);
         chk("b_dout", b_dout, m_dout);
         if (m_req) chk("b_idx", b_idx, m_idx);
      end
   end

   task automatic run_a(input logic [127:0] d, input logic [127:0] k1,
                        input logic [127:0] exp, input string nm);
      int n;
      a_keys[1] = k1;
      a_din = d; a_start = 1; a_rk_valid = 1;
      @(negedge clk);
      a_start = 0; n = 1;
      while (!a_done && n < 20) begin
         chk({nm, "_req"}, a_req, 1'b1);
         chk({nm, "_idx"}, a_idx, n - 1);
         @(negedge clk); n++;
      end
      chk({nm, "_lat"}, n, 3);
      chk({nm, "_dout"}, a_dout, exp);
      chk({nm, "_model"}, model_enc(d, 1, a_keys), exp);
      chk({nm, "_busy_done"}, a_busy, 1'b1);
      @(negedge clk);
      chk({nm, "_busy_after"}, a_busy, 1'b0);
      chk({nm, "_done_after"}, a_done, 1'b0);
      chk({nm, "_dout_held"}, a_dout, exp);
   endtask

   task automatic run_b(input int pct, input bit spam, input string nm);
      int n, stalls;
      logic [127:0] d0;
      d0 = {$urandom, $urandom, $urandom, $urandom};
      b_din = d0; b_start = 1; b_rk_valid = 1;
      @(negedge clk);
      b_start = 0; n = 1; stalls = 0;
      while (!b_done && n < 1000) begin
         b_rk_valid = ($urandom_range(0, 99) >= pct);
         if (spam) begin
            b_start = 1'($urandom_range(0, 1));
            b_din = {$urandom, $urandom, $urandom, $urandom};
         end
         if (b_req && !b_rk_valid) stalls++;
         @(negedge clk); n++;
      end
      b_start = 0; b_rk_valid = 0;
      chk({nm, "_done_seen"}, b_done, 1'b1);
      chk({nm, "_lat"}, n, 27 + stalls);
      chk({nm, "_dout"}, b_dout, model_enc(d0, 25, b_keys));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      int n;
      logic [127:0] old;
      rst = 1;
      a_start = 0; a_din = '0; a_rk_valid = 0;
      b_start = 0; b_din = '0; b_rk_valid = 0;
`ifdef BLK_ABORT_EN
      a_abort = 0; b_abort = 0;
`endif
      for (int i = 0; i < 26; i++) begin
         a_keys[i] = '0;
         b_keys[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      repeat (3) @(negedge clk);
      rst = 0; chk_en = 1;
      repeat (5) @(negedge clk);
      chk("rst_a_req", a_req, 1'b0);
      chk("rst_a_idx", a_idx, 0);
      chk("rst_a_busy", a_busy, 1'b0);
      chk("rst_a_done", a_done, 1'b0);
      chk("rst_a_dout", a_dout, 128'h0);
      chk("rst_b_idx", b_idx, 0);
      chk("rst_b_dout", b_dout, 128'h0);

      run_a(128'h1, 128'h0, 128'h6000, "a_one");
      run_a({128{1'b1}}, 128'h0, 128'h55555555_AAAAAAAA_55555555_AAAAAAAA, "a_ones");
      run_a(128'h0, 128'hDEAD_BEEF, 128'hDEAD_BEEF, "a_key");

      run_b(0, 0, "b_nostall");
      run_b(50, 0, "b_stall");
      run_b(50, 1, "b_spam");

      b_din = {$urandom, $urandom, $urandom, $urandom}; b_start = 1; b_rk_valid = 1;
      @(negedge clk);
      b_start = 0;
      repeat (4) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("midrst_busy", b_busy, 1'b0);
      chk("midrst_req", b_req, 1'b0);
      chk("midrst_done", b_done, 1'b0);
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (b_done) seen = 1;
      end
      chk("midrst_no_done", seen, 1'b0);
      run_b(30, 0, "b_after_rst");

`ifdef BLK_ABORT_EN
      old = b_dout;
      b_din = {$urandom, $urandom, $urandom, $urandom}; b_start = 1; b_rk_valid = 1;
      @(negedge clk);
      b_start = 0; n = 0;
      while (b_idx != 5'd3 && n < 50) begin
         @(negedge clk); n++;
      end
      chk("abort_reach_idx3", b_idx, 3);
      b_abort = 1; b_rk_valid = 1;
      @(negedge clk);
      b_abort = 0; b_rk_valid = 0;
      chk("abort_busy", b_busy, 1'b0);
      chk("abort_req", b_req, 1'b0);
      chk("abort_dout", b_dout, old);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (b_done) seen = 1;
      end
      chk("abort_no_done", seen, 1'b0);
      run_b(0, 0, "b_after_abort");
`else
      old = '0;
      n = 0;
`endif

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/blk_round_ctrl.md
# blk_round_ctrl

Iterative round controller for the 128-bit lightweight block cipher. It owns the cipher state register and sequences one shared `Subsell_layer` instance through ROUNDS rounds, each computed as AddRoundKey, then SubCells, then ShiftRow. Round keys are fetched one at a time from an external key schedule over a request/valid handshake. The block sits between the top-level start/done interface and the key-schedule unit.

## Interface
- `ROUNDS`, default 25: number of full rounds; ROUNDS+1 round keys are consumed (last is output whitening). Legal range 1..(2^CNT_W − 1).
- `CNT_W`, default 5: width of round counter and `rk_idx`.

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin encryption of `din`; sampled only in IDLE.
- `din`  in  128  plaintext; captured on accepted `start`.
- `rk_req`  out  1  round key requested.
- `rk_idx`  out  CNT_W  index of requested key (0..ROUNDS).
- `rk_valid`  in  1  `rk` valid for `rk_idx`; consumed when `rk_req && rk_valid`.
- `rk`  in  128  round key.
- `busy`  out  1  high from accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse; `dout` valid from this cycle.
- `dout`  out  128  ciphertext; held until next `done`.
- `abort`  in  1  present only with `BLK_ABORT_EN`.

## Operation
- ShiftRow: state rows are row0=[127:96], row1=[95:64], row2=[63:32], row3=[31:0]. Rows are rotated left by 0, 1, 12 and 13 respectively.
- SubCells: the `Subsell_layer` instance, with S-box table 0,3,7,E,D,4,A,9,C,F,1,8,B,2,6,5, applied to all 32 nibbles. It is the only S-box hardware in the block and is used once per round.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - `start` → `state<=din`, `cnt<=0`, go to FETCH.
  - `start` is ignored in every other state.
- FETCH:
  - `rk_req=1`, `rk_idx=cnt`.
  - On handshake with `cnt<ROUNDS`: `state<=ShiftRow(SubCells(state^rk))`, `cnt<=cnt+1`, stay in FETCH.
  - On handshake with `cnt==ROUNDS`: `dout<=state^rk`, go to DONE.
  - Without handshake: hold everything. Wait states are unbounded.
- DONE: `done=1` for one cycle, then go to IDLE.
- `rk_valid` outside FETCH is ignored.
- Counter never wraps: it stops at ROUNDS.
- Reset values: `state`=0, `dout`=0, `cnt`=0, `rk_req`=0, `rk_idx`=0, `busy`=0, `done`=0, FSM=IDLE.
- Reset mid-operation discards the operation; no `done` is generated.

## Timing
- `start` at cycle 0 with `rk_valid` tied high:
  - FETCH occupies cycles 1..ROUNDS+1.
  - `done` and valid `dout` appear at cycle ROUNDS+2.
  - Each low cycle of `rk_valid` adds one cycle of latency.
- `rk_req`/`rk_idx` are registered outputs (FSM/counter-derived, no combinational path from inputs).
- `busy` is high during FETCH and DONE.
- Back-to-back: `start` is accepted at the earliest in the cycle after DONE, i.e. in IDLE.
- One S-box pass per clock. The critical path is `rk` XOR → SubCells → rotate → state register.

## Configuration
- `BLK_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort` high in FETCH returns the FSM to IDLE next cycle, drops `rk_req`/`busy`, and suppresses `done`. `dout` keeps its previous value.
  - `abort` in IDLE or DONE has no effect.
  - If `abort` and a handshake occur in the same cycle, `abort` wins and the key is not used.
- `BLK_ABORT_EN` undefined: no `abort` port and no abort logic.

## Test plan
- Reset, then idle 5 cycles → all outputs 0. Pulse `rst` during FETCH → IDLE next cycle, `busy`=0, no `done`.
- ROUNDS=1, `din`=128'h1, all keys 0, `rk_valid`=1 → `done` at cycle 3, `dout`=128'h6000.
- ROUNDS=1, `din`=all-ones, keys 0 → `dout`=128'h55555555_AAAAAAAA_55555555_AAAAAAAA.
- ROUNDS=1, `din`=0, rk0=0, rk1=128'hDEAD_BEEF → `dout`=128'hDEAD_BEEF. `rk_idx` sequence is 0, 1.
- ROUNDS=25, `rk_valid` randomly deasserted ~50% → `dout` matches the reference model, `rk_idx` walks 0..25 without skips, latency is 27 cycles + stall count, and `start` pulses while busy are ignored.
- `BLK_ABORT_EN`: `abort` at `rk_idx`=3 → IDLE next cycle, no `done`, `dout` unchanged. A new `start` then completes correctly.
